// File: rtl/state.sv
// Control-state sequencer for the tinycpu core: IDLE, then a five-phase instruction loop.
// HLT freezes the loop and cont resumes it. The registered state code is driven onto cs.
module state (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       cont,
    input  logic       halt,
    output logic [2:0] cs
);

    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StIf   = 3'b001,
        StId   = 3'b010,
        StEx   = 3'b011,
        StMem  = 3'b100,
        StWb   = 3'b101,
        StHlt  = 3'b110,
        StBad  = 3'b111
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // halt wins over run, so the machine stays in IDLE when both are high
            StIdle: if (run && !halt) state_d = StIf;
            StIf:   state_d = halt ? StHlt : StId;
            StId:   state_d = halt ? StHlt : StEx;
            StEx:   state_d = halt ? StHlt : StMem;
            StMem:  state_d = halt ? StHlt : StWb;
            StWb:   state_d = halt ? StHlt : StIf;
            StHlt: begin
                if (halt) begin
                    state_d = StHlt;
                end else if (cont) begin
                    state_d = StIf;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cs = state_q;
    end

endmodule

// File: tb/tb_state.sv
// Scoreboard bench for the tinycpu control-state sequencer.
// Expected cs codes are queued as stimulus is applied and popped one edge later.
module tb_state;

    logic       clk;
    logic       reset;
    logic       run;
    logic       cont;
    logic       halt;
    logic [2:0] cs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];

    state dut (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .cont (cont),
        .halt (halt),
        .cs   (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step word layout: {reset, run, cont, halt, expected cs}.
    task automatic apply(input logic [6:0] step);
        reset = step[6];
        run   = step[5];
        cont  = step[4];
        halt  = step[3];
        exp_q.push_back(step[2:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [6:0] tbl [0:1];
        logic [2:0] want;
        tbl = '{7'b0100_000, 7'b0100_000};
        for (int i = 0; i < 2; i++) begin
            apply(tbl[i]);
            want = exp_q.pop_front();
            n_checks++;
            if (cs !== want) begin
                n_fail++;
                $display("FAIL reset step %0d: cs=%b expected %b", i, cs, want);
            end
        end
    endtask

    task automatic test_run_sequence;
        logic [6:0] tbl [0:7];
        logic [2:0] want;
        tbl = '{7'b1100_001, 7'b1000_010, 7'b1000_011, 7'b1000_100,
                7'b1000_101, 7'b1000_001, 7'b1000_010, 7'b1000_011};
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i]);
            want = exp_q.pop_front();
            n_checks++;
            if (cs !== want) begin
                n_fail++;
                $display("FAIL run_sequence step %0d: cs=%b expected %b", i, cs, want);
            end
        end
    endtask

    // Entered with cs=EX; cont and run must not disturb the loop.
    task automatic test_cont_ignored;
        logic [6:0] tbl [0:2];
        logic [2:0] want;
        tbl = '{7'b1010_100, 7'b1110_101, 7'b1010_001};
        for (int i = 0; i < 3; i++) begin
            apply(tbl[i]);
            want = exp_q.pop_front();
            n_checks++;
            if (cs !== want) begin
                n_fail++;
                $display("FAIL cont_ignored step %0d: cs=%b expected %b", i, cs, want);
            end
        end
    endtask

    // Entered with cs=IF; walk to WB, halt there, hold, then resume.
    task automatic test_halt_cont;
        logic [6:0] tbl [0:10];
        logic [2:0] want;
        tbl = '{7'b1000_010, 7'b1000_011, 7'b1000_100, 7'b1000_101,
                7'b1001_110, 7'b1000_110, 7'b1000_110, 7'b1100_110,
                7'b1010_001, 7'b1000_010, 7'b1000_011};
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i]);
            want = exp_q.pop_front();
            n_checks++;
            if (cs !== want) begin
                n_fail++;
                $display("FAIL halt_cont step %0d: cs=%b expected %b", i, cs, want);
            end
        end
    endtask

    // Entered with cs=EX. Halt out of every phase, with halt+cont held in HLT.
    task automatic test_halt_each_phase;
        logic [6:0] steps[$];
        logic [2:0] want;
        steps.push_back(7'b1001_110);
        for (int k = 1; k <= 5; k++) begin
            steps.push_back(7'b1011_110);
            steps.push_back(7'b1010_001);
            for (int j = 2; j <= k; j++) begin
                steps.push_back({4'b1000, 3'(j)});
            end
            steps.push_back(7'b1001_110);
        end
        foreach (steps[i]) begin
            apply(steps[i]);
            want = exp_q.pop_front();
            n_checks++;
            if (cs !== want) begin
                n_fail++;
                $display("FAIL halt_each_phase step %0d: cs=%b expected %b", i, cs, want);
            end
        end
    endtask

    // Entered in HLT. Reset from HLT and from EX, then check IDLE priorities.
    task automatic test_reset_mid;
        logic [6:0] tbl [0:11];
        logic [2:0] want;
        tbl = '{7'b0011_000, 7'b1100_001, 7'b1000_010, 7'b1000_011,
                7'b0000_000, 7'b1001_000, 7'b1011_000, 7'b1101_000,
                7'b1100_001, 7'b1100_010, 7'b0100_000, 7'b1010_000};
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            want = exp_q.pop_front();
            n_checks++;
            if (cs !== want) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: cs=%b expected %b", i, cs, want);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b0;
        cont  = 1'b0;
        halt  = 1'b0;
        test_reset();
        test_run_sequence();
        test_cont_ignored();
        test_halt_cont();
        test_halt_each_phase();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/state.md
Name: state

Overview:
- Top-level control-state sequencer for the tinycpu core.
- After `run`, it steps the CPU through a fixed five-phase instruction cycle: fetch, decode, execute, memory, write-back.
- It publishes the current phase on `cs` for the datapath control decode.
- `halt` freezes execution in a halt state; `cont` resumes it.

Parameters:
- None. State encodings are fixed local constants:
  - IDLE=3'b000
  - IF=3'b001
  - ID=3'b010
  - EX=3'b011
  - MEM=3'b100
  - WB=3'b101
  - HLT=3'b110
  - 3'b111 unused

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- run  input  1  start request; only honoured in IDLE
- cont  input  1  continue request; only honoured in HLT
- halt  input  1  stop request; honoured in IF/ID/EX/MEM/WB
- cs  output  3  current state code (registered)

Behaviour:
- Moore machine; `cs` is the state register itself, with no combinational path from inputs to `cs`.
- Reset: `reset`=0 at a rising clk sets `cs`=IDLE (000) next cycle, regardless of other inputs or current state, including mid-cycle or HLT. While `reset` is held low, `cs` stays 000.
- Until the first clock edge after power-up, `cs` is undefined; the bench must apply reset first.
- Transitions (evaluated only when `reset`=1), listed in priority order:
  - IDLE: `run`=1 → IF; otherwise stay IDLE. `halt`/`cont` ignored. If `halt`=1 and `run`=1 together, stay IDLE (halt wins).
  - IF, ID, EX, MEM, WB: `halt`=1 → HLT (next cycle, from any of these phases).
  - Otherwise: IF→ID→EX→MEM→WB→IF, one phase per clock, looping indefinitely.
  - `run` and `cont` are ignored in these phases.
  - HLT: `halt`=1 → stay HLT (halt has priority over `cont`). Else `cont`=1 → IF. Else stay HLT. `run` ignored.
  - Code 111 (illegal): → IDLE on next edge.
- Inputs are level-sampled at each edge. A 1-cycle pulse is sufficient; a held level is re-evaluated every cycle.
- Leaving HLT or IDLE requires one edge: `cs` shows IF on the cycle after `cont`/`run` is sampled.
- Latency from any input sample to the `cs` change is exactly one clock.
- Only reset returns the machine to IDLE; `halt` never does.

Test Plan:
- Reset: hold `reset`=0 with `run`=1 for 2 edges → `cs`=000 both cycles.
- Run sequence: release `reset`, pulse `run`=1 for one edge.
  - `cs` = 001, 010, 011, 100, 101, then 001 again on successive edges.
  - `cs` keeps looping with `run` now 0.
- `cont` ignored while running: assert `cont`=1 for one edge while `cs`=011 → next `cs`=100 (normal advance).
- Halt/continue:
  - Assert `halt` for one edge while `cs`=101 → `cs`=110, and `cs` stays 110 with all inputs low.
  - Then pulse `cont` → `cs`=001, and the cycle resumes 010, 011…
- Priority:
  - In HLT, assert `halt`=1 and `cont`=1 together → `cs` stays 110.
  - In IDLE, assert `run`=1 and `halt`=1 together → `cs` stays 000.
- Reset mid-operation: drive `reset`=0 while `cs`=011, and separately while `cs`=110 → `cs`=000 next edge in both cases. `halt` pulsed in IDLE → `cs` stays 000.
